// File: rtl/complete_buffer_if.sv
// complete_buffer_if: FU result ports, squash, and ROB/CDB complete outputs of the complete stage
interface complete_buffer_if #(
    parameter int NUM_FU    = 4,
    parameter int BUF_DEPTH = 8,
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 5,
    parameter int TAG_W     = 6
);
    logic                        squash;
    logic [NUM_FU-1:0]           fu_valid;
    logic [NUM_FU-1:0]           fu_ready;
    logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx;
    logic [NUM_FU*TAG_W-1:0]     fu_tag;
    logic [NUM_FU-1:0]           fu_tag_valid;
    logic [NUM_FU*XLEN-1:0]      fu_result;
    logic [NUM_FU*XLEN-1:0]      fu_rs2_value;
    logic [NUM_FU-1:0]           fu_take_branch;
    logic                        complete_en;
    logic [ROB_IDX_W-1:0]        complete_idx;
    logic [XLEN-1:0]             result;
    logic [XLEN-1:0]             rs2_value;
    logic                        take_branch;
    logic                        cdb_valid;
    logic [TAG_W-1:0]            cdb_tag;
    logic [$clog2(BUF_DEPTH):0]  count;
    modport master (
        output squash, fu_valid, fu_rob_idx, fu_tag, fu_tag_valid, fu_result, fu_rs2_value, fu_take_branch,
        input  fu_ready, complete_en, complete_idx, result, rs2_value, take_branch, cdb_valid, cdb_tag, count
    );
    modport slave (
        input  squash, fu_valid, fu_rob_idx, fu_tag, fu_tag_valid, fu_result, fu_rs2_value, fu_take_branch,
        output fu_ready, complete_en, complete_idx, result, rs2_value, take_branch, cdb_valid, cdb_tag, count
    );
endinterface

// File: rtl/complete_buffer.sv
// complete_buffer: circular FIFO collecting FU results, draining one per cycle to the ROB and CDB
module complete_buffer #(
    parameter int NUM_FU    = 4,
    parameter int BUF_DEPTH = 8,
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 5,
    parameter int TAG_W     = 6
) (
    input logic clock,
    input logic reset,
    complete_buffer_if.slave bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]        head, tail;
    logic [CW-1:0]        count_q, space, n_acc;
    logic [BUF_DEPTH-1:0] ent_v, ent_tv, ent_tb;
    logic [ROB_IDX_W-1:0] ent_idx [BUF_DEPTH];
    logic [TAG_W-1:0]     ent_tag [BUF_DEPTH];
    logic [XLEN-1:0]      ent_res [BUF_DEPTH];
    logic [XLEN-1:0]      ent_rs2 [BUF_DEPTH];
    logic [NUM_FU-1:0]    rdy, acc;
    logic [PW-1:0]        wptr [NUM_FU];
    logic                 pop;

    assign pop   = count_q != '0;
    assign space = CW'(BUF_DEPTH) - count_q + CW'(pop);

    // Port i is ready when enough slots remain for every valid lower-index port plus itself
    always_comb begin
        logic [CW-1:0] run;
        run   = '0;
        n_acc = '0;
        rdy   = '0;
        acc   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            rdy[i]  = !reset || (!bus.squash && space > run);
            acc[i]  = bus.fu_valid[i] && rdy[i];
            wptr[i] = tail + run[PW-1:0];
            run     = run + CW'(bus.fu_valid[i]);
            n_acc   = n_acc + CW'(acc[i]);
        end
    end

    // Pointer, occupancy and entry-valid tracking; squash empties the buffer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            ent_v   <= '0;
        end else if (bus.squash) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            ent_v   <= '0;
        end else begin
            head    <= head + PW'(pop);
            tail    <= tail + n_acc[PW-1:0];
            count_q <= count_q + n_acc - CW'(pop);
            if (pop) ent_v[head] <= 1'b0;
            for (int i = 0; i < NUM_FU; i++)
                if (acc[i]) ent_v[wptr[i]] <= 1'b1;
        end
    end

    // Payload storage; contents only matter where the entry is valid
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++)
            if (acc[i]) begin
                ent_idx[wptr[i]] <= bus.fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                ent_tag[wptr[i]] <= bus.fu_tag[i*TAG_W +: TAG_W];
                ent_tv[wptr[i]]  <= bus.fu_tag_valid[i];
                ent_res[wptr[i]] <= bus.fu_result[i*XLEN +: XLEN];
                ent_rs2[wptr[i]] <= bus.fu_rs2_value[i*XLEN +: XLEN];
                ent_tb[wptr[i]]  <= bus.fu_take_branch[i];
            end
    end

    assign bus.fu_ready     = rdy;
    assign bus.count        = count_q;
    assign bus.complete_en  = pop;
    assign bus.complete_idx = pop ? ent_idx[head] : '0;
    assign bus.result       = pop ? ent_res[head] : '0;
    assign bus.rs2_value    = pop ? ent_rs2[head] : '0;
    assign bus.take_branch  = pop && ent_tb[head];
    assign bus.cdb_valid    = pop && ent_v[head] && ent_tv[head];
    assign bus.cdb_tag      = pop ? ent_tag[head] : '0;

    // A stalled FU must keep presenting the same result until it is taken
    for (genvar g = 0; g < NUM_FU; g++) begin : g_hold
        a_hold: assert property (@(posedge clock) disable iff (!reset)
            bus.fu_valid[g] && !bus.fu_ready[g] && !bus.squash |=>
            bus.fu_valid[g] && $stable(bus.fu_rob_idx[g*ROB_IDX_W +: ROB_IDX_W]));
    end
endmodule

// File: tb/tb_complete_buffer.sv
// tb_complete_buffer: directed checks of the complete buffer's FIFO, back-pressure, squash and reset
module tb_complete_buffer;
    logic clock;
    logic reset;
    int   n_tot = 0;
    int   n_bad = 0;

    complete_buffer_if bus ();

    complete_buffer dut (.clock(clock), .reset(reset), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic put(input int p, input logic [4:0] idx, input logic [5:0] tg, input logic tv,
                       input logic [31:0] res, input logic [31:0] rs2, input logic br);
        bus.fu_valid[p]            = 1'b1;
        bus.fu_rob_idx[p*5 +: 5]   = idx;
        bus.fu_tag[p*6 +: 6]       = tg;
        bus.fu_tag_valid[p]        = tv;
        bus.fu_result[p*32 +: 32]  = res;
        bus.fu_rs2_value[p*32 +: 32] = rs2;
        bus.fu_take_branch[p]      = br;
    endtask

    initial begin
        logic tb_br;
        reset = 1'b1;
        bus.squash = 1'b0;
        bus.fu_valid = '0;
        bus.fu_rob_idx = '0;
        bus.fu_tag = '0;
        bus.fu_tag_valid = '0;
        bus.fu_result = '0;
        bus.fu_rs2_value = '0;
        bus.fu_take_branch = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_en", 64'(bus.complete_en), 0);
        check("rst_rdy", 64'(bus.fu_ready), 4'hf);
        check("rst_cnt", 64'(bus.count), 0);
        @(negedge clock) reset = 1'b1;
        tick;
        check("idle_en", 64'(bus.complete_en), 0);
        check("idle_cnt", 64'(bus.count), 0);
        check("idle_rdy", 64'(bus.fu_ready), 4'hf);

        put(0, 5, 12, 1, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        #1 check("one_rdy", 64'(bus.fu_ready), 4'hf);
        tick;
        bus.fu_valid = '0;
        #1;
        check("one_en", 64'(bus.complete_en), 1);
        check("one_idx", 64'(bus.complete_idx), 5);
        check("one_tag", 64'(bus.cdb_tag), 12);
        check("one_cdb", 64'(bus.cdb_valid), 1);
        check("one_res", 64'(bus.result), 64'hDEAD_BEEF);
        check("one_rs2", 64'(bus.rs2_value), 64'h1234_5678);
        check("one_cnt", 64'(bus.count), 1);
        tick;
        check("one_drain", 64'(bus.complete_en), 0);

        for (int p = 0; p < 4; p++) put(p, 5'(p + 1), 6'(p + 1), 1, 0, 0, 0);
        #1 check("burst_rdy", 64'(bus.fu_ready), 4'hf);
        tick;
        bus.fu_valid = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("burst_idx", 64'(bus.complete_idx), 64'(k + 1));
            check("burst_cnt", 64'(bus.count), 64'(4 - k));
            tick;
        end
        check("burst_empty", 64'(bus.complete_en), 0);

        for (int p = 0; p < 4; p++) put(p, 5'(10 + p), 0, 1, 0, 0, 0);
        tick;
        for (int p = 0; p < 4; p++) put(p, 5'(14 + p), 0, 1, 0, 0, 0);
        #1;
        check("fill_rdy", 64'(bus.fu_ready), 4'hf);
        check("fill_head", 64'(bus.complete_idx), 10);
        tick;
        bus.fu_valid = '0;
        put(0, 18, 0, 1, 0, 0, 0);
        put(1, 19, 0, 1, 0, 0, 0);
        #1 check("fill2_rdy", 64'(bus.fu_ready), 4'b0011);
        tick;
        bus.fu_valid = '0;
        put(1, 20, 0, 1, 0, 0, 0);
        put(2, 21, 0, 1, 0, 0, 0);
        #1;
        check("full_cnt", 64'(bus.count), 8);
        check("full_rdy", 64'(bus.fu_ready), 4'b0011);
        check("full_acc", 64'(bus.fu_ready & bus.fu_valid), 4'b0010);
        check("full_head", 64'(bus.complete_idx), 12);
        tick;
        bus.fu_valid[1] = 1'b0;
        #1;
        check("held_acc", 64'(bus.fu_ready & bus.fu_valid), 4'b0100);
        check("held_cnt", 64'(bus.count), 8);
        check("held_head", 64'(bus.complete_idx), 13);
        tick;
        bus.fu_valid = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("order_idx", 64'(bus.complete_idx), 64'(14 + k));
            check("order_cnt", 64'(bus.count), 64'(8 - k));
            tick;
        end
        check("order_empty", 64'(bus.count), 0);

        for (int k = 0; k < 20; k++) begin
            tb_br = k[0];
            put(0, 5'(k), 6'(k + 1), k != 7, 32'(k * 3), 0, tb_br);
            tick;
            check("wrap_idx", 64'(bus.complete_idx), 64'(k));
            check("wrap_cdb", 64'(bus.cdb_valid), (k != 7) ? 64'd1 : 64'd0);
            check("wrap_br", 64'(bus.take_branch), 64'(k % 2));
            check("wrap_cnt", 64'(bus.count), 1);
        end
        bus.fu_valid = '0;
        tick;
        check("wrap_empty", 64'(bus.complete_en), 0);

        for (int p = 0; p < 4; p++) put(p, 5'(p), 0, 1, 0, 0, 0);
        tick;
        bus.fu_valid = '0;
        put(0, 4, 0, 1, 0, 0, 0);
        put(1, 5, 0, 1, 0, 0, 0);
        tick;
        bus.fu_valid = '0;
        #1 check("sq_pre_cnt", 64'(bus.count), 5);
        bus.squash = 1'b1;
        put(0, 6, 0, 1, 0, 0, 0);
        #1;
        check("sq_rdy", 64'(bus.fu_ready), 0);
        check("sq_en", 64'(bus.complete_en), 1);
        tick;
        bus.squash = 1'b0;
        bus.fu_valid = '0;
        #1;
        check("sq_cnt", 64'(bus.count), 0);
        check("sq_en_after", 64'(bus.complete_en), 0);
        for (int p = 0; p < 3; p++) put(p, 5'(7 + p), 0, 1, 0, 0, 0);
        tick;
        bus.fu_valid = '0;
        #1;
        check("rf_cnt", 64'(bus.count), 3);
        check("rf_idx", 64'(bus.complete_idx), 7);
        #2 reset = 1'b0;
        #1;
        check("ar_en", 64'(bus.complete_en), 0);
        check("ar_cnt", 64'(bus.count), 0);
        check("ar_cdb", 64'(bus.cdb_valid), 0);
        check("ar_idx", 64'(bus.complete_idx), 0);
        check("ar_rdy", 64'(bus.fu_ready), 4'hf);
        @(negedge clock) reset = 1'b1;
        tick;
        check("ar_post_cnt", 64'(bus.count), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
